hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Parametrised successor to the stall-only hazard detector of the 5-stage 16-bit pipeline.
- Keeps a per-register age scoreboard of in-flight writes. Each cycle it either generates forwarding selects or stalls, with load-use awareness.
- Counts stall cycles for debug display on HEX/LEDR.
- Sits beside ID. It drives the PC enable, the IF/ID enable and the ID/EX bubble select, and feeds registered forwarding selects to EX.

Parameters:
- ADDR_W, 3, register address width; NREGS = 2**ADDR_W.
- DEPTH, 3, pipeline registers between ID/EX output and the RF write (EX/MEM=1, MEM/WB=2, WB=3); legal range 3..8.
- FWD_EN, 1, 1 = forwarding enabled; 0 = pure stall mode, same behaviour as the current HDU.
- LOAD_REG, 2, first pipeline register index where a load result exists; range 1..DEPTH-1.
- R0_ZERO, 1, 1 = register 0 is never tracked and never hazards.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src1  in  ADDR_W  read address 1 of the ID instruction
- id_src1_used  in  1  src1 is actually read
- id_src2  in  ADDR_W  read address 2
- id_src2_used  in  1  src2 is actually read
- id_dst  in  ADDR_W  write address of the ID instruction
- id_wr_en  in  1  ID instruction writes the RF
- id_is_load  in  1  ID instruction is a load
- flush  in  1  branch taken; the ID instruction is killed this cycle
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- bubble  out  1  ID/EX loads a NOP this cycle
- ex_fwd1  out  3  EX operand-1 source: 0 = ID/EX read value, k = pipeline register k
- ex_fwd2  out  3  EX operand-2 source, same encoding
- stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard state per register r:
  - age[r], in 0..DEPTH-1; 0 = not pending.
  - ld[r], 1 bit.
  - age[r]=a>=1 means the youngest in-flight writer of r sits in pipeline register a, i.e. it was issued a cycles ago.
- issue = id_valid & ~stall & ~flush.
- Per-cycle update, in this order:
  - Every nonzero age increments by 1. An age reaching DEPTH becomes 0: the RF is written and RF read is write-before-read.
  - Then, if issue & id_wr_en & ~(R0_ZERO & id_dst==0): age[id_dst] <= 1 and ld[id_dst] <= id_is_load. This overrides any older entry, so the youngest writer wins.
- Hazard on a source s (used, valid, not R0 when R0_ZERO), with a = age[s] at ID time:
  - a == 0: no hazard; fwd = 0.
  - FWD_EN=0 and a >= 1: stall.
  - FWD_EN=1 and ld[s]=0: fwd = a, no stall.
  - FWD_EN=1 and ld[s]=1: stall if a < LOAD_REG, else fwd = a.
- stall is the OR of both sources' stall conditions, gated by ~flush. Combinational outputs:
  - pc_en = ~stall.
  - if_id_en = ~stall.
  - bubble = stall | flush.
- Flush wins over stall. During a flush, pc_en=1 and nothing is issued.
- Ages keep advancing during a stall, so every stall resolves within DEPTH-1 cycles.
- ex_fwd1/ex_fwd2 are registered: captured on issue, otherwise loaded with 0 (a bubble forwards nothing). They are valid during the consumer's EX cycle.
- stall_cnt increments by 1 every cycle stall=1 and saturates at all-ones; it never wraps.
- rst: all ages and ld cleared, ex_fwd1/2 = 0, stall_cnt = 0. The cycle after reset: pc_en=1, if_id_en=1, bubble=0. Reset mid-stall discards all pending entries.
- Simultaneous issue to r and expiry of the old r entry in the same cycle: the issue wins, and age[r] = 1.
- Both sources equal to the same pending register: both selects are set identically.

Test Plan:
- Reset with all defaults, then ADD r1 followed immediately by SUB r2,r1,r1 -> no stall, ex_fwd1 = ex_fwd2 = 1 in SUB's EX cycle, stall_cnt = 0.
- LW r3 followed by ADD r4,r3,r5 -> exactly 1 stall cycle (pc_en=0, bubble=1), then ex_fwd1 = 2, ex_fwd2 = 0, stall_cnt = 1.
- FWD_EN=0: ADD r1 then use of r1 -> 2 stall cycles, no forwarding, stall_cnt = 2.
- ADD r1 whose RAW consumer is in ID while flush=1 -> bubble=1, pc_en=1, no stall counted, the killed instruction never appears in the scoreboard.
- Write to r0 with R0_ZERO=1 then read r0 -> no stall, fwd = 0.
- Two writes to r6 back-to-back then a read of r6 -> fwd = 1 (the youngest writer); force stall_cnt to 16'hFFFF, one more stall -> it stays 16'hFFFF; rst asserted mid-stall -> the next cycle pc_en=1 and stall_cnt = 0.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - age-scoreboard hazard detection and forwarding select unit
module hazard_fwd_unit #(
    parameter int ADDR_W   = 3,
    parameter int DEPTH    = 3,
    parameter int FWD_EN   = 1,
    parameter int LOAD_REG = 2,
    parameter int R0_ZERO  = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_src1,
    input  logic              id_src1_used,
    input  logic [ADDR_W-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic [ADDR_W-1:0] id_dst,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              bubble,
    output logic [2:0]        ex_fwd1,
    output logic [2:0]        ex_fwd2,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int NREGS = 2 ** ADDR_W;
    // Ages never exceed DEPTH-1 <= 7, which is also the forwarding select range.
    localparam int AGE_W = 3;
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(DEPTH - 1);
    localparam logic [AGE_W-1:0] AGE_LOAD = AGE_W'(LOAD_REG);

    logic [NREGS-1:0][AGE_W-1:0] age_q;
    logic [NREGS-1:0][AGE_W-1:0] age_n;
    logic [NREGS-1:0]            ld_q;
    logic [NREGS-1:0]            ld_n;

    logic             stall1;
    logic             stall2;
    logic             stall;
    logic             issue;
    logic             dst_tracked;
    logic [AGE_W-1:0] fwd1;
    logic [AGE_W-1:0] fwd2;

    // Returns {stall, fwd_select} for one source operand given the scoreboard.
    function automatic logic [AGE_W:0] eval_src(
        input logic [ADDR_W-1:0]          src,
        input logic                       used,
        input logic                       valid,
        input logic [NREGS-1:0][AGE_W-1:0] ages,
        input logic [NREGS-1:0]           lds
    );
        logic [AGE_W-1:0] a;
        logic             st;
        logic [AGE_W-1:0] f;
        a  = ages[src];
        st = 1'b0;
        f  = '0;
        if (valid && used && !(R0_ZERO != 0 && src == '0) && a != '0) begin
            if (FWD_EN == 0) begin
                st = 1'b1;
            end else if (lds[src] && a < AGE_LOAD) begin
                // Load data not yet available in pipeline register a.
                st = 1'b1;
            end else begin
                f = a;
            end
        end
        return {st, f};
    endfunction

    // Hazard decision for the instruction in ID; flush overrides any stall.
    always_comb begin
        {stall1, fwd1} = eval_src(id_src1, id_src1_used, id_valid, age_q, ld_q);
        {stall2, fwd2} = eval_src(id_src2, id_src2_used, id_valid, age_q, ld_q);
        stall       = (stall1 | stall2) & ~flush;
        issue       = id_valid & ~stall & ~flush;
        dst_tracked = id_wr_en && !(R0_ZERO != 0 && id_dst == '0);
        pc_en       = ~stall;
        if_id_en    = ~stall;
        bubble      = stall | flush;
    end

    // Scoreboard next state: age every pending writer, then record the new issue.
    always_comb begin
        age_n = age_q;
        ld_n  = ld_q;
        for (int r = 0; r < NREGS; r++) begin
            if (age_q[r] == '0 || age_q[r] == AGE_LAST) begin
                age_n[r] = '0;
            end else begin
                age_n[r] = age_q[r] + AGE_W'(1);
            end
        end
        // The youngest writer replaces whatever entry was there, even one expiring now.
        if (issue && dst_tracked) begin
            age_n[id_dst] = AGE_W'(1);
            ld_n[id_dst]  = id_is_load;
        end
    end

    // Scoreboard, registered forwarding selects and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q     <= '0;
            ld_q      <= '0;
            ex_fwd1   <= '0;
            ex_fwd2   <= '0;
            stall_cnt <= '0;
        end else begin
            age_q   <= age_n;
            ld_q    <= ld_n;
            ex_fwd1 <= issue ? fwd1 : 3'd0;
            ex_fwd2 <= issue ? fwd2 : 3'd0;
            if (stall && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - scoreboard bench for hazard_fwd_unit
module tb_hazard_fwd_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [2:0] s1;
        logic       u1;
        logic [2:0] s2;
        logic       u2;
        logic [2:0] dst;
        logic       wr;
        logic       ld;
        logic       flush;
    } in_t;

    typedef struct {
        bit pc_en;
        bit if_id_en;
        bit bubble;
        int f1;
        int f2;
        int cnt;
    } exp_t;

    typedef struct {
        int k;
        int dst;
        bit ld;
        int t;
    } wr_t;

    // Instance 0: defaults. Instance 1: stall-only. Instance 2: deeper pipe, 2-bit counter.
    int depth   [3] = '{3, 3, 5};
    int fwden   [3] = '{1, 0, 1};
    int loadreg [3] = '{2, 2, 3};
    int cntmax  [3] = '{65535, 65535, 3};

    in_t  din [3];
    exp_t exq [3][$];
    wr_t  wrq [$];
    int   cyc = 0;
    int   m_f1 [3];
    int   m_f2 [3];
    int   m_cnt [3];
    bit   m_stall [3];
    int   total = 0;
    int   bad = 0;

    logic       pc_en_o [3];
    logic       ifid_o  [3];
    logic       bub_o   [3];
    logic [2:0] f1_o    [3];
    logic [2:0] f2_o    [3];
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    hazard_fwd_unit dut0 (
        .clk(clk), .rst(din[0].rst), .id_valid(din[0].valid),
        .id_src1(din[0].s1), .id_src1_used(din[0].u1),
        .id_src2(din[0].s2), .id_src2_used(din[0].u2),
        .id_dst(din[0].dst), .id_wr_en(din[0].wr), .id_is_load(din[0].ld),
        .flush(din[0].flush), .pc_en(pc_en_o[0]), .if_id_en(ifid_o[0]),
        .bubble(bub_o[0]), .ex_fwd1(f1_o[0]), .ex_fwd2(f2_o[0]), .stall_cnt(cnt0)
    );

    hazard_fwd_unit #(.FWD_EN(0)) dut1 (
        .clk(clk), .rst(din[1].rst), .id_valid(din[1].valid),
        .id_src1(din[1].s1), .id_src1_used(din[1].u1),
        .id_src2(din[1].s2), .id_src2_used(din[1].u2),
        .id_dst(din[1].dst), .id_wr_en(din[1].wr), .id_is_load(din[1].ld),
        .flush(din[1].flush), .pc_en(pc_en_o[1]), .if_id_en(ifid_o[1]),
        .bubble(bub_o[1]), .ex_fwd1(f1_o[1]), .ex_fwd2(f2_o[1]), .stall_cnt(cnt1)
    );

    hazard_fwd_unit #(.DEPTH(5), .LOAD_REG(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(din[2].rst), .id_valid(din[2].valid),
        .id_src1(din[2].s1), .id_src1_used(din[2].u1),
        .id_src2(din[2].s2), .id_src2_used(din[2].u2),
        .id_dst(din[2].dst), .id_wr_en(din[2].wr), .id_is_load(din[2].ld),
        .flush(din[2].flush), .pc_en(pc_en_o[2]), .if_id_en(ifid_o[2]),
        .bubble(bub_o[2]), .ex_fwd1(f1_o[2]), .ex_fwd2(f2_o[2]), .stall_cnt(cnt2)
    );

    function automatic logic [31:0] cnt_of(input int k);
        case (k)
            0:       return {16'd0, cnt0};
            1:       return {16'd0, cnt1};
            default: return {30'd0, cnt2};
        endcase
    endfunction

    function automatic void chk(input string name, input int k, input logic [31:0] act, input int expv);
        total++;
        if (act !== expv[31:0]) begin
            bad++;
            $display("FAIL %s inst%0d: got %0d expected %0d", name, k, act, expv);
        end
    endfunction

    // Age of the youngest in-flight writer of r, derived from issue timestamps.
    function automatic void age_of(input int k, input int r, output int a, output bit l);
        a = 0;
        l = 1'b0;
        for (int i = wrq.size() - 1; i >= 0; i--) begin
            if (wrq[i].k == k && wrq[i].dst == r) begin
                if (cyc - wrq[i].t < depth[k]) begin
                    a = cyc - wrq[i].t;
                    l = wrq[i].ld;
                end
                return;
            end
        end
    endfunction

    function automatic void src_eval(input int k, input int s, input bit used, input bit valid,
                                     output bit st, output int f);
        int a;
        bit l;
        st = 1'b0;
        f  = 0;
        if (!valid || !used || s == 0) return;
        age_of(k, s, a, l);
        if (a == 0) return;
        if (fwden[k] == 0) st = 1'b1;
        else if (l && a < loadreg[k]) st = 1'b1;
        else f = a;
    endfunction

    function automatic void model_step(input int k);
        in_t  i;
        bit   st1, st2, stall, iss;
        int   f1, f2;
        exp_t e;
        i = din[k];
        src_eval(k, int'(i.s1), i.u1, i.valid, st1, f1);
        src_eval(k, int'(i.s2), i.u2, i.valid, st2, f2);
        stall = (st1 | st2) & !i.flush;
        e.pc_en    = !stall;
        e.if_id_en = !stall;
        e.bubble   = stall | i.flush;
        e.f1       = m_f1[k];
        e.f2       = m_f2[k];
        e.cnt      = m_cnt[k];
        exq[k].push_back(e);
        m_stall[k] = stall;
        if (i.rst) begin
            m_f1[k]  = 0;
            m_f2[k]  = 0;
            m_cnt[k] = 0;
            for (int j = wrq.size() - 1; j >= 0; j--)
                if (wrq[j].k == k) wrq.delete(j);
        end else begin
            iss = i.valid & !stall & !i.flush;
            m_f1[k] = iss ? f1 : 0;
            m_f2[k] = iss ? f2 : 0;
            if (stall && m_cnt[k] < cntmax[k]) m_cnt[k]++;
            if (iss && i.wr && i.dst != 3'd0)
                wrq.push_back('{k: k, dst: int'(i.dst), ld: i.ld, t: cyc});
        end
    endfunction

    task automatic cycle();
        for (int k = 0; k < 3; k++) model_step(k);
        cyc++;
        @(posedge clk);
        #1;
        while (wrq.size() > 0 && cyc - wrq[0].t >= 8) void'(wrq.pop_front());
    endtask

    function automatic in_t idle();
        in_t r;
        r = '0;
        return r;
    endfunction

    function automatic in_t ins(input int dst, input bit wr, input bit ld,
                                input int s1, input bit u1, input int s2, input bit u2);
        in_t r;
        r = '0;
        r.valid = 1'b1;
        r.dst = 3'(dst); r.wr = wr; r.ld = ld;
        r.s1 = 3'(s1); r.u1 = u1;
        r.s2 = 3'(s2); r.u2 = u2;
        return r;
    endfunction

    // Hold an instruction in ID until it issues, then leave ID empty.
    task automatic issue(input int k, input in_t x);
        int n = 0;
        din[k] = x;
        do begin
            cycle();
            n++;
        end while (m_stall[k] && n < 20);
        if (n >= 20) chk("issue_timeout", k, 32'd1, 0);
        din[k] = idle();
    endtask

    // Monitor: one expected record per instance per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (exq[k].size() > 0) begin
                    e = exq[k].pop_front();
                    chk("pc_en",     k, 32'(pc_en_o[k]), int'(e.pc_en));
                    chk("if_id_en",  k, 32'(ifid_o[k]),  int'(e.if_id_en));
                    chk("bubble",    k, 32'(bub_o[k]),   int'(e.bubble));
                    chk("ex_fwd1",   k, 32'(f1_o[k]),    e.f1);
                    chk("ex_fwd2",   k, 32'(f2_o[k]),    e.f2);
                    chk("stall_cnt", k, cnt_of(k),       e.cnt);
                end
            end
        end
    end

    initial begin
        in_t x;
        for (int k = 0; k < 3; k++) begin
            din[k] = idle();
            din[k].rst = 1'b1;
            m_f1[k] = 0; m_f2[k] = 0; m_cnt[k] = 0; m_stall[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        cycle();
        for (int k = 0; k < 3; k++) din[k] = idle();
        cycle();

        // ADD r1; SUB r2,r1,r1 -> forwarded from EX/MEM on both operands.
        issue(0, ins(1, 1, 0, 0, 0, 0, 0));
        issue(0, ins(2, 1, 0, 1, 1, 1, 1));
        chk("addsub_fwd1", 0, 32'(f1_o[0]), 1);
        chk("addsub_fwd2", 0, 32'(f2_o[0]), 1);
        chk("addsub_cnt", 0, cnt_of(0), 0);

        // LW r3; ADD r4,r3,r5 -> one load-use stall, then forward from MEM/WB.
        issue(0, ins(3, 1, 1, 0, 0, 0, 0));
        issue(0, ins(4, 1, 0, 3, 1, 5, 1));
        chk("loaduse_fwd1", 0, 32'(f1_o[0]), 2);
        chk("loaduse_fwd2", 0, 32'(f2_o[0]), 0);
        chk("loaduse_cnt", 0, cnt_of(0), 1);

        // Flushed consumer writing r7 must never be tracked.
        issue(0, ins(1, 1, 0, 0, 0, 0, 0));
        x = ins(7, 1, 0, 1, 1, 0, 0);
        x.flush = 1'b1;
        din[0] = x;
        cycle();
        din[0] = idle();
        issue(0, ins(2, 1, 0, 7, 1, 0, 0));
        chk("flush_untracked", 0, 32'(f1_o[0]), 0);
        chk("flush_cnt", 0, cnt_of(0), 1);

        // Writes to r0 are ignored.
        issue(0, ins(0, 1, 1, 0, 0, 0, 0));
        issue(0, ins(5, 1, 0, 0, 1, 0, 1));
        chk("r0_fwd1", 0, 32'(f1_o[0]), 0);
        chk("r0_cnt", 0, cnt_of(0), 1);

        // Two back-to-back writers of r6: the youngest is forwarded.
        issue(0, ins(6, 1, 0, 0, 0, 0, 0));
        issue(0, ins(6, 1, 0, 0, 0, 0, 0));
        issue(0, ins(2, 1, 0, 6, 1, 6, 1));
        chk("youngest_fwd1", 0, 32'(f1_o[0]), 1);
        chk("youngest_fwd2", 0, 32'(f2_o[0]), 1);

        // Stall-only mode: two stall cycles, nothing forwarded.
        issue(1, ins(1, 1, 0, 0, 0, 0, 0));
        issue(1, ins(2, 1, 0, 1, 1, 0, 0));
        chk("nofwd_cnt", 1, cnt_of(1), 2);
        chk("nofwd_fwd1", 1, 32'(f1_o[1]), 0);

        // Reset while a stall is in progress discards the pending writer.
        issue(1, ins(1, 1, 0, 0, 0, 0, 0));
        din[1] = ins(2, 1, 0, 1, 1, 0, 0);
        cycle();
        din[1].rst = 1'b1;
        cycle();
        din[1] = ins(2, 1, 0, 1, 1, 0, 0);
        chk("rst_cnt", 1, cnt_of(1), 0);
        chk("rst_pc_en", 1, 32'(pc_en_o[1]), 1);
        cycle();
        din[1] = idle();

        // 2-bit counter saturates after repeated two-cycle load-use stalls.
        for (int n = 0; n < 2; n++) begin
            issue(2, ins(1, 1, 1, 0, 0, 0, 0));
            issue(2, ins(2, 1, 0, 1, 1, 0, 0));
        end
        chk("sat_cnt", 2, cnt_of(2), 3);
        chk("sat_fwd1", 2, 32'(f1_o[2]), 3);

        // Randomized traffic on all instances.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                x = '0;
                x.rst   = ($urandom_range(0, 63) == 0);
                x.valid = ($urandom_range(0, 3) != 0);
                x.s1    = 3'($urandom_range(0, 7));
                x.u1    = 1'($urandom_range(0, 1));
                x.s2    = 3'($urandom_range(0, 7));
                x.u2    = 1'($urandom_range(0, 1));
                x.dst   = 3'($urandom_range(0, 7));
                x.wr    = ($urandom_range(0, 3) != 0);
                x.ld    = ($urandom_range(0, 2) == 0);
                x.flush = ($urandom_range(0, 7) == 0);
                din[k]  = x;
            end
            cycle();
        end
        for (int k = 0; k < 3; k++) din[k] = idle();
        cycle();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
